coin_change_dispenser: RTL

// - Return-side counterpart of the coin collector: emits coins instead of accepting them.
// - Given a refund/change amount in paise, drives the coin mechanism one coin at a time.
// - Uses the collector's coin code, greedy 1 rupee -> 50p -> 25p, with a ready/ack handshake.
// - Sits between vending control (start/amount) and the coin-eject mechanism (coin/ack).

---
 rtl/coin_change_dispenser.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser
//   Pays out a refund one coin at a time, largest coin first (1 rupee, 50p, 25p),
//   using the same coin code as the coin collector. Each coin is presented on
//   coin/coin_valid and held until the eject mechanism acknowledges it. After
//   every ack the mechanism gets COIN_GAP idle cycles to settle before the next
//   coin is presented.
//
// Handshake: coin/coin_valid form a valid/ack pair. While coin_valid is high,
//   coin is stable. A coin is consumed on a rising clock edge where coin_valid
//   and coin_ack are both high. coin_ack while coin_valid is low has no effect.
//   start is a one-cycle request, honoured only while busy is low.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   refund request (sampled only in IDLE)
//   amount     in   refund in paise, sampled with start
//   coin_ack   in   mechanism has ejected the presented coin
//   coin       out  00=25p, 01=50p, 10=1 rupee, 11=no coin
//   coin_valid out  coin holds a real coin awaiting coin_ack
//   busy       out  a refund is in progress
//   done       out  one-cycle pulse when the refund is fully paid out
//   error      out  one-cycle pulse when a request is rejected
//   remaining  out  paise still to dispense
//   fsm_state  out  current state, for debug and checkers
module coin_change_dispenser #(
  parameter int               AMT_W    = 8,
  parameter logic [AMT_W-1:0] MAX_AMT  = AMT_W'(175),
  parameter int               COIN_GAP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  output logic [1:0]       coin,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;

  localparam logic [1:0] COIN_25   = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_NONE = 2'b11;

  localparam logic [AMT_W-1:0] VAL_25  = AMT_W'(25);
  localparam logic [AMT_W-1:0] VAL_50  = AMT_W'(50);
  localparam logic [AMT_W-1:0] VAL_100 = AMT_W'(100);

  localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP + 1) : 1;

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic [AMT_W-1:0] rem_next;
  logic             bad_amount;

  function automatic logic [1:0] greedy(input logic [AMT_W-1:0] x);
    if (x >= VAL_100)     greedy = COIN_100;
    else if (x >= VAL_50) greedy = COIN_50;
    else                  greedy = COIN_25;
  endfunction

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_100: coin_value = VAL_100;
      COIN_50:  coin_value = VAL_50;
      COIN_25:  coin_value = VAL_25;
      default:  coin_value = '0;
    endcase
  endfunction

  // Greedy on a 25p multiple never overshoots, so this cannot underflow.
  assign rem_next   = remaining - coin_value(coin);
  assign bad_amount = ((amount % VAL_25) != '0) || (amount > MAX_AMT);
  assign fsm_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      coin       <= COIN_NONE;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      remaining  <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bad_amount) begin
              error <= 1'b1;
            end else if (amount == '0) begin
              done <= 1'b1;
            end else begin
              remaining  <= amount;
              coin       <= greedy(amount);
              coin_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (coin_ack) begin
            remaining  <= rem_next;
            coin       <= COIN_NONE;
            coin_valid <= 1'b0;
            if (rem_next == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_W'(COIN_GAP);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // A count of 0 or 1 both mean "present on this edge", so even a zero
          // gap spends one cycle here with no coin shown.
          if (gap_cnt <= GAP_W'(1)) begin
            coin       <= greedy(remaining);
            coin_valid <= 1'b1;
            state      <= S_PRESENT;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          coin       <= COIN_NONE;
          coin_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
